// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the successive-approximation search controller:
//   - state_t        : controller state encoding (IDLE, SETTLE)
//   - CMP_GT/EQ/LT   : comparator reply codes as {cmp_gt, cmp_eq, cmp_lt}
//   - is_one_hot()   : true when a reply is exactly one legal code
// -----------------------------------------------------------------------------
package sar_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    // A comparator that reports none or several relations at once is broken
    // (or its inputs are not settled); the search cannot trust that reply.
    function automatic logic is_one_hot(input logic [2:0] reply);
        return (reply == CMP_GT) || (reply == CMP_EQ) || (reply == CMP_LT);
    endfunction

endpackage

// File: rtl/sar_search.sv
// -----------------------------------------------------------------------------
// sar_search
// Successive-approximation search controller. Presents a trial value to an
// external magnitude comparator whose other operand is a hidden target, and
// rebuilds that target bit by bit from the gt/eq/lt replies, MSB first.
//
// Parameters
//   WIDTH    trial/result width (>= 2)
//   CMP_LAT  cycles each trial is held before the reply is sampled (>= 1)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a search (only looked at while idle)
//   cmp_gt   in   comparator: trial >  target
//   cmp_eq   in   comparator: trial == target
//   cmp_lt   in   comparator: trial <  target
//   trial    out  value driven into the comparator
//   busy     out  search in progress
//   done     out  one-cycle pulse, result valid
//   hit      out  search ended on an exact-equal reply
//   err      out  one-cycle pulse, illegal reply, search aborted
//   result   out  recovered value, held until the next done
// -----------------------------------------------------------------------------
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int K_W   = $clog2(WIDTH);
    localparam int CNT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

    localparam logic [K_W-1:0]   K_TOP     = K_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CMP_LAT - 1);
    localparam logic [WIDTH-1:0] TRIAL_TOP = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_trial,  w_trial_nxt;
    logic [K_W-1:0]   r_k,      w_k_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_hit,    w_hit_nxt;
    logic             r_err,    w_err_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;

    logic [2:0]       w_reply;
    logic [WIDTH-1:0] w_corrected;

    assign w_reply = {cmp_gt, cmp_eq, cmp_lt};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_k_nxt      = r_k;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_hit_nxt    = r_hit;
        w_result_nxt = r_result;

        // Trial with the bit under test resolved: a "too big" reply means the
        // target has a 0 in this position, otherwise the 1 stays.
        w_corrected = r_trial;
        if (w_reply == CMP_GT) begin
            w_corrected[r_k] = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_trial_nxt = TRIAL_TOP;
                    w_k_nxt     = K_TOP;
                    w_cnt_nxt   = CNT_LOAD;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (r_cnt != '0) begin
                    // Comparator still settling on the current trial.
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!is_one_hot(w_reply)) begin
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (w_reply == CMP_EQ) begin
                    // Exact match ends the search early; lower bits are moot.
                    w_result_nxt = r_trial;
                    w_hit_nxt    = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if (r_k == '0) begin
                    w_trial_nxt  = w_corrected;
                    w_result_nxt = w_corrected;
                    w_hit_nxt    = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_trial_nxt              = w_corrected;
                    w_trial_nxt[r_k - 1'b1]  = 1'b1;
                    w_k_nxt                  = r_k - 1'b1;
                    w_cnt_nxt                = CNT_LOAD;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_trial  <= '0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hit    <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the
            // same pre-edge values, regardless of statement order.
            r_state  <= w_state_nxt;
            r_trial  <= w_trial_nxt;
            r_k      <= w_k_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_hit    <= w_hit_nxt;
            r_err    <= w_err_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign trial  = r_trial;
    assign busy   = r_busy;
    assign done   = r_done;
    assign hit    = r_hit;
    assign err    = r_err;
    assign result = r_result;

endmodule
